// File: rtl/pwm_gen.sv
// pwm_gen: fixed-frequency PWM for one LED pin, duty 0..100 % sampled at period boundaries.
// Latency: en to first period_start is 1 clk; pwm_out is registered and moves with the tick counter.
// Backpressure: none; en is honoured only in IDLE or at a period boundary, so periods always complete.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   en            : run request
//   pwm_value     : requested duty in percent (signed, clamped to 0..100)
//   pwm_out       : pin drive (ACTIVE_LOW selects lit level)
//   period_start  : one-cycle pulse on the first cycle of each period
//   duty_active   : clamped duty latched for the current period
module pwm_gen #(
  parameter int PRESCALE   = 120,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [31:0] pwm_value,
  output logic               pwm_out,
  output logic               period_start,
  output logic [6:0]         duty_active
);

  // A prescale of 1 still needs a 1-bit counter that simply stays at 0.
  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic          DARK    = ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic          LIT     = ~DARK;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [PW-1:0] prescale;
  logic [6:0]    tick;
  logic [6:0]    duty_clamped;

  always_comb begin
    duty_clamped = 7'd0;
    if (pwm_value < 0)
      duty_clamped = 7'd0;
    else if (pwm_value > 100)
      duty_clamped = 7'd100;
    else
      duty_clamped = pwm_value[6:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      prescale     <= '0;
      tick         <= 7'd0;
      duty_active  <= 7'd0;
      period_start <= 1'b0;
      pwm_out      <= DARK;
    end else begin
      period_start <= 1'b0;
      case (state)
        IDLE: begin
          prescale <= '0;
          tick     <= 7'd0;
          pwm_out  <= DARK;
          if (en) begin
            state        <= RUN;
            duty_active  <= duty_clamped;
            period_start <= 1'b1;
            // Tick 0 is lit for any non-zero duty.
            pwm_out      <= (duty_clamped != 7'd0) ? LIT : DARK;
          end
        end
        RUN: begin
          if (prescale == PS_LAST) begin
            prescale <= '0;
            if (tick == 7'd99) begin
              tick <= 7'd0;
              if (en) begin
                duty_active  <= duty_clamped;
                period_start <= 1'b1;
                // Lit level carries straight across the boundary for duty 100.
                pwm_out      <= (duty_clamped != 7'd0) ? LIT : DARK;
              end else begin
                state   <= IDLE;
                pwm_out <= DARK;
              end
            end else begin
              tick    <= tick + 7'd1;
              // Evaluate against the tick value being loaded this edge.
              pwm_out <= ((tick + 7'd1) < duty_active) ? LIT : DARK;
            end
          end else begin
            prescale <= prescale + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: randomized drive of two pwm_gen instances (different prescale/polarity)
// against a period-position reference model; every output checked each cycle.
// Async reset is exercised mid-lit-phase and checked before any clock edge.
module tb_pwm_gen;

  logic               clk;
  logic               rst;
  logic               en;
  logic signed [31:0] pwm_value;

  logic       pwm_out_a, period_start_a;
  logic [6:0] duty_active_a;
  logic       pwm_out_b, period_start_b;
  logic [6:0] duty_active_b;

  pwm_gen #(.PRESCALE(2), .ACTIVE_LOW(1'b0)) u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .pwm_value    (pwm_value),
    .pwm_out      (pwm_out_a),
    .period_start (period_start_a),
    .duty_active  (duty_active_a)
  );

  pwm_gen #(.PRESCALE(3), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .pwm_value    (pwm_value),
    .pwm_out      (pwm_out_b),
    .period_start (period_start_b),
    .duty_active  (duty_active_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: position k within a period of 100*P cycles.
  int m_run  [2];
  int m_k    [2];
  int m_duty [2];
  int m_ps   [2];
  int m_p    [2] = '{2, 3};
  int m_al   [2] = '{0, 1};

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 100) return 100;
    return v;
  endfunction

  function automatic int exp_pin(input int i);
    int lit;
    lit = (m_run[i] != 0) && (m_k[i] < m_duty[i] * m_p[i]);
    return (m_al[i] != 0) ? (lit ? 0 : 1) : (lit ? 1 : 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_k[i] = 0; m_duty[i] = 0; m_ps[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_run[i] = 0; m_k[i] = 0; m_duty[i] = 0; m_ps[i] = 0;
      end else if (m_run[i] == 0) begin
        m_ps[i] = 0;
        if (en) begin
          m_run[i] = 1; m_k[i] = 0; m_duty[i] = clamp(pwm_value); m_ps[i] = 1;
        end
      end else if (m_k[i] == 100 * m_p[i] - 1) begin
        m_k[i] = 0;
        if (en) begin
          m_duty[i] = clamp(pwm_value); m_ps[i] = 1;
        end else begin
          m_run[i] = 0; m_ps[i] = 0;
        end
      end else begin
        m_k[i]++;
        m_ps[i] = 0;
      end
    end
  endtask

  task automatic compare_all(input string phase);
    check({phase, "_a_pwm_out"},      int'(pwm_out_a),      exp_pin(0));
    check({phase, "_a_period_start"}, int'(period_start_a), m_ps[0]);
    check({phase, "_a_duty_active"},  int'(duty_active_a),  m_duty[0]);
    check({phase, "_b_pwm_out"},      int'(pwm_out_b),      exp_pin(1));
    check({phase, "_b_period_start"}, int'(period_start_b), m_ps[1]);
    check({phase, "_b_duty_active"},  int'(duty_active_b),  m_duty[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all("run");
  endtask

  // Assert reset between edges and check the outputs before any clock edge.
  task automatic do_async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    step();
    rst = 1'b0;
  endtask

  function automatic int pick_value();
    case ($urandom_range(0, 5))
      0:       return -int'($urandom_range(1, 1000));
      1:       return 100 + int'($urandom_range(1, 100000));
      2:       return 0;
      3:       return 100;
      default: return int'($urandom_range(0, 100));
    endcase
  endfunction

  int n_resets = 0;

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    pwm_value = 25;
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (cyc >= 1200) begin
        if ($urandom_range(0, 59) == 0) pwm_value = pick_value();
        if (en && $urandom_range(0, 399) == 0) en = 1'b0;
        else if (!en && $urandom_range(0, 39) == 0) en = 1'b1;
      end
      if (cyc == 600) pwm_value = 70;
      if (n_resets < 3 && cyc > (n_resets + 1) * 5000 && exp_pin(1) == 0) begin
        n_resets++;
        do_async_reset();
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
